// File: rtl/agriculture_soc_pkg.sv
// Shared constants and the sensor LFSR step function for the agriculture demo SoC.
package agriculture_soc_pkg;

    localparam int          DEF_SAMPLE_PERIOD  = 1000;
    localparam int          DEF_HEARTBEAT_HALF = 2500;
    localparam logic [7:0]  DEF_MOIST_LOW      = 8'd80;
    localparam logic [7:0]  DEF_MOIST_HIGH     = 8'd160;
    localparam logic [7:0]  DEF_TEMP_ALARM     = 8'd200;
    localparam logic [15:0] DEF_LFSR_SEED      = 16'hACE1;

    localparam int LED_HEARTBEAT = 0;
    localparam int LED_PUMP      = 1;
    localparam int LED_ALARM     = 2;
    localparam int LED_SAMPLE    = 3;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

endpackage

// File: rtl/agri_sensor_lfsr.sv
// Pseudo-random soil sensor: a 16-bit LFSR split into moisture (low) and temperature (high).
module agri_sensor_lfsr
    import agriculture_soc_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = DEF_LFSR_SEED
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic [7:0] moisture,
    output logic [7:0] temperature
);

    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= LFSR_SEED;
        end else if (advance) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign moisture    = lfsr[7:0];
    assign temperature = lfsr[15:8];

endmodule

// File: rtl/agriculture_soc.sv
// Agriculture demo SoC top: sample timer, hysteretic pump control, temperature alarm
// and heartbeat, all reported on four board LEDs.
module agriculture_soc
    import agriculture_soc_pkg::*;
#(
    parameter int          SAMPLE_PERIOD  = DEF_SAMPLE_PERIOD,
    parameter int          HEARTBEAT_HALF = DEF_HEARTBEAT_HALF,
    parameter logic [7:0]  MOIST_LOW      = DEF_MOIST_LOW,
    parameter logic [7:0]  MOIST_HIGH     = DEF_MOIST_HIGH,
    parameter logic [7:0]  TEMP_ALARM     = DEF_TEMP_ALARM,
    parameter logic [15:0] LFSR_SEED      = DEF_LFSR_SEED
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] LED
);

    localparam int SW = $clog2(SAMPLE_PERIOD + 1);
    localparam int HW = $clog2(HEARTBEAT_HALF + 1);

    logic [SW-1:0] sample_cnt;
    logic [HW-1:0] hb_cnt;
    logic          sample_tick;
    logic          hb_wrap;
    logic          eval_pending;
    logic [3:0]    led_q;
    logic [7:0]    moisture;
    logic [7:0]    temperature;

    assign sample_tick = (sample_cnt == SW'(SAMPLE_PERIOD - 1));
    assign hb_wrap     = (hb_cnt == HW'(HEARTBEAT_HALF - 1));

    agri_sensor_lfsr #(
        .LFSR_SEED (LFSR_SEED)
    ) u_sensor (
        .clk         (clk),
        .reset       (reset),
        .advance     (sample_tick),
        .moisture    (moisture),
        .temperature (temperature)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_cnt   <= '0;
            eval_pending <= 1'b0;
        end else begin
            sample_cnt   <= sample_tick ? '0 : sample_cnt + 1'b1;
            eval_pending <= sample_tick;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hb_cnt <= '0;
        end else begin
            hb_cnt <= hb_wrap ? '0 : hb_cnt + 1'b1;
        end
    end

    // Evaluation runs one edge after the tick so it sees the freshly advanced LFSR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q <= 4'b0000;
        end else begin
            if (hb_wrap) begin
                led_q[LED_HEARTBEAT] <= ~led_q[LED_HEARTBEAT];
            end
            if (eval_pending) begin
                led_q[LED_SAMPLE] <= ~led_q[LED_SAMPLE];
                led_q[LED_ALARM]  <= (temperature >= TEMP_ALARM);
                // Inside the band [MOIST_LOW, MOIST_HIGH] the pump keeps its state.
                if (moisture < MOIST_LOW) begin
                    led_q[LED_PUMP] <= 1'b1;
                end else if (moisture > MOIST_HIGH) begin
                    led_q[LED_PUMP] <= 1'b0;
                end
            end
        end
    end

    assign LED = led_q;

endmodule

// File: tb/tb_agriculture_soc.sv
// Directed bench for agriculture_soc: default instance plus one with overridden thresholds.
module tb_agriculture_soc;

    logic       clk;
    logic       reset;
    logic [3:0] led_a;
    logic [3:0] led_b;

    int errors = 0;
    int checks = 0;
    int cur    = 0;
    int hb_toggles = 0;

    agriculture_soc dut_a (
        .clk   (clk),
        .reset (reset),
        .LED   (led_a)
    );

    agriculture_soc #(
        .MOIST_LOW  (8'd56),
        .TEMP_ALARM (8'd171)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .LED   (led_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(led_a[0]) begin
        if (reset === 1'b1) hb_toggles++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h exp=0x%0h (edge %0d)", tag, got, exp, cur);
        end
    endtask

    // driver tasks
    task automatic go_to(input int n);
        while (cur < n) begin
            @(posedge clk);
            cur++;
        end
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        cur   = 0;
    endtask

    task automatic assert_reset_between_edges();
        @(posedge clk);
        cur++;
        #3;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_led_a", 32'(led_a), 32'h0);
        check("rst_led_b", 32'(led_b), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_led_a", 32'(led_a), 32'h0);
        check("rst_moist", 32'(dut_a.u_sensor.moisture), 32'd225);
        check("rst_temp", 32'(dut_a.u_sensor.temperature), 32'd172);

        hb_toggles = 0;
        release_reset();
        go_to(998);
        check("pre_sample_998", 32'(led_a), 32'h0);
        go_to(1000);
        check("tick_edge_led", 32'(led_a), 32'h0);
        check("s1_moist", 32'(dut_a.u_sensor.moisture), 32'd112);
        check("s1_temp", 32'(dut_a.u_sensor.temperature), 32'd86);
        go_to(1001);
        check("s1_led_a", 32'(led_a), 32'b1000);
        check("s1_led_b", 32'(led_b), 32'b1000);
        go_to(2000);
        check("s2_pre_led_a", 32'(led_a), 32'b1000);
        check("s2_moist", 32'(dut_a.u_sensor.moisture), 32'd56);
        check("s2_temp", 32'(dut_a.u_sensor.temperature), 32'd171);
        go_to(2001);
        check("s2_led_a", 32'(led_a), 32'b0010);
        check("s2_led_b_low_eq", 32'(led_b), 32'b0100);
        go_to(2499);
        check("hb_2499", 32'(led_a[0]), 32'd0);
        go_to(2500);
        check("hb_2500", 32'(led_a[0]), 32'd1);
        go_to(3001);
        check("s3_led_a_hold", 32'(led_a), 32'b1011);
        check("s3_led_b_hold", 32'(led_b), 32'b1001);
        go_to(4001);
        check("s4_led_a_off", 32'(led_a), 32'b0001);
        check("s4_led_b_off", 32'(led_b), 32'b0001);
        go_to(5000);
        check("hb_5000", 32'(led_a[0]), 32'd0);
        go_to(10001);
        check("hb_toggles", 32'(hb_toggles), 32'd4);
        check("hb_10001", 32'(led_a[0]), 32'd0);

        // Mid-run asynchronous reset
        reset = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        go_to(1499);
        assert_reset_between_edges();
        check("async_rst_led_a", 32'(led_a), 32'h0);
        check("async_rst_led_b", 32'(led_b), 32'h0);
        check("async_rst_moist", 32'(dut_a.u_sensor.moisture), 32'd225);
        repeat (3) @(posedge clk);
        #1;
        check("async_rst_hold", 32'(led_a), 32'h0);
        release_reset();
        go_to(1000);
        check("restart_moist", 32'(dut_a.u_sensor.moisture), 32'd112);
        check("restart_temp", 32'(dut_a.u_sensor.temperature), 32'd86);
        go_to(1001);
        check("restart_led_a", 32'(led_a), 32'b1000);

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/agriculture_soc.md
Name: agriculture_soc

Overview:
Self-contained top-level SoC for the agriculture demo board. It models a soil-moisture/temperature sensor with an internal LFSR, sampled at a fixed period. It applies irrigation control with hysteresis and a temperature alarm. Status is driven to four board LEDs; there are no other I/O beyond clock and reset.

Parameters:
SAMPLE_PERIOD, 1000, clock cycles between sensor samples (>=2)
HEARTBEAT_HALF, 2500, clock cycles per heartbeat LED half-period (>=1)
MOIST_LOW, 8'd80, moisture below this turns pump on
MOIST_HIGH, 8'd160, moisture above this turns pump off (MOIST_HIGH > MOIST_LOW)
TEMP_ALARM, 8'd200, temperature >= this raises the alarm
LFSR_SEED, 16'hACE1, sensor LFSR reset value (nonzero)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
LED  output  4  [0] heartbeat, [1] pump on, [2] temperature alarm, [3] sample toggle

Behaviour:
- One clock `clk`; `reset` is asynchronous and active-low. All registers clear immediately when reset=0 and hold while it stays low.
- Reset values: LED=4'b0000, sample counter=0, heartbeat counter=0, lfsr=LFSR_SEED, eval_pending=0.
- Sample timer: counts 0..SAMPLE_PERIOD-1 every cycle, then wraps to 0. sample_tick=1 when count==SAMPLE_PERIOD-1, so the first tick is on the 1000th rising edge after reset release.
- Sensor LFSR: 16-bit Fibonacci, taps 16,14,13,11.
  - Feedback fb = lfsr[0]^lfsr[2]^lfsr[3]^lfsr[5]; next = {fb, lfsr[15:1]}.
  - Advances only on the edge where sample_tick=1; eval_pending is set on that same edge.
- Decoded values: moisture = lfsr[7:0], temperature = lfsr[15:8], both unsigned 8-bit.
- Evaluation stage: on the edge where eval_pending=1 (one cycle after tick):
  - LED[3] toggles.
  - LED[1] (pump): set if moisture < MOIST_LOW; cleared if moisture > MOIST_HIGH; otherwise holds (hysteresis).
  - LED[2] (alarm) <= (temperature >= TEMP_ALARM). It is re-evaluated every sample, no latching.
  - eval_pending clears.
- Latency: LED[1..3] change exactly 1 cycle after the tick edge, i.e. 2 edges after count reaches SAMPLE_PERIOD-1.
- Heartbeat: its own counter 0..HEARTBEAT_HALF-1; LED[0] toggles on wrap. The first toggle is on the 2500th edge after reset release, independent of sampling.
- Boundaries:
  - moisture == MOIST_LOW or == MOIST_HIGH: pump holds.
  - temperature == TEMP_ALARM: alarm on.
  - The tick and the eval stage never coincide, because SAMPLE_PERIOD>=2.
- Reset mid-operation: all state returns to reset values asynchronously. The LFSR restarts from LED_SEED (LFSR_SEED), so the sample sequence is repeatable.

Decomposition:
- Package agriculture_soc_pkg: default parameter constants, LED bit index constants (LED_HEARTBEAT=0, LED_PUMP=1, LED_ALARM=2, LED_SAMPLE=3), and the LFSR tap function.
- One sub-module, agri_sensor_lfsr: inputs clk, reset, advance; outputs moisture[7:0], temperature[7:0].
- Timers, hysteresis control and LED registers live in the top.

Test Plan:
- Reset: hold reset=0 for 5 cycles -> LED=0000, no change while low. Release and run 998 edges -> LED still 0000.
- First sample: edge 1000 ticks, LFSR 0xACE1->0x5670 (moisture 112, temp 86). Edge 1001 -> LED[3]=1, LED[1]=0 (mid band, holds 0), LED[2]=0.
- Second sample: LFSR 0x5670->0xAB38 (moisture 56, temp 171). Edge 2001 -> LED[1]=1, LED[2]=0, LED[3]=0.
- Heartbeat: LED[0]=0 through edge 2499, 1 at edge 2500, 0 at edge 5000. About 10001 cycles -> exactly 4 toggles.
- Hysteresis/alarm with overridden parameters:
  - MOIST_LOW=56 -> moisture 56 does not set pump.
  - TEMP_ALARM=171 -> LED[2]=1 at edge 2001.
- Async reset mid-run: assert reset=0 at cycle 1500, between clock edges -> LED=0000 immediately. After release, the first sample again yields LFSR 0x5670 at edge 1000 after release.
